// File: rtl/jtag_dr_master_if.sv
// Host-side command/response port of the JTAG DR scan master.
// The host drives a command word; the master answers with a one-cycle
// response pulse carrying the word it captured from the target.
`timescale 1ns/1ps

interface jtag_dr_master_if;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [7:0] cmd_data;
    logic [2:0] cmd_addr;
    logic       rsp_valid;
    logic [7:0] rsp_data;
    logic [2:0] rsp_addr;

    // Host / sequencer side
    modport master (
        output cmd_valid, cmd_data, cmd_addr,
        input  cmd_ready, rsp_valid, rsp_data, rsp_addr
    );

    // Scan engine side
    modport slave (
        input  cmd_valid, cmd_data, cmd_addr,
        output cmd_ready, rsp_valid, rsp_data, rsp_addr
    );
endinterface

// File: rtl/jtag_dr_master.sv
// JTAG initiator performing one 11-bit DR scan ({data[7:0],addr[2:0]},
// LSB first) per accepted command, optionally preceded by a
// Test-Logic-Reset prefix. TCK is clk_sys_i divided by 2*g_clk_div.
// TMS/TDI move only when TCK is driven low (or at accept); TDO is
// sampled when TCK is driven high.
`timescale 1ns/1ps

module jtag_dr_master #(
    parameter int g_clk_div = 4
) (
    input  logic              clk_sys_i,
    input  logic              rst_n_i,
    jtag_dr_master_if.slave   host,
    input  logic              tap_reset_i,
    output logic              busy_o,
    output logic              tck_o,
    output logic              tms_o,
    output logic              tdi_o,
    input  logic              tdo_i
);

    // Each state names the TAP transition made at the next TCK rising edge.
    // ST_ENT_SH is the CaptureDR -> ShiftDR edge; ST_SHIFT covers the 11
    // shifting edges, the last of which also moves the TAP to Exit1-DR.
    typedef enum logic [3:0] {
        ST_IDLE,
        ST_TLR,
        ST_TLR_RTI,
        ST_SEL_DR,
        ST_CAP_DR,
        ST_ENT_SH,
        ST_SHIFT,
        ST_UPD_DR,
        ST_RTI_END
    } state_t;

    localparam int              DIV_W   = (g_clk_div > 1) ? $clog2(g_clk_div) : 1;
    localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(g_clk_div - 1);

    state_t           state_q, state_d;
    logic [3:0]       cnt_q, cnt_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic             tck_q, tck_d;
    logic             tms_q, tms_d;
    logic             tdi_q, tdi_d;
    logic [10:0]      word_q, word_d;
    logic [10:0]      cap_q, cap_d;
    logic             rsp_valid_q, rsp_valid_d;
    logic [7:0]       rsp_data_q, rsp_data_d;
    logic [2:0]       rsp_addr_q, rsp_addr_d;
    logic             ready_q, ready_d;
    logic             known_q, known_d;
    logic             tlr_pend_q, tlr_pend_d;

    logic accept;
    logic div_tick;
    logic tck_rise;
    logic tck_fall;

    assign accept   = ready_q & host.cmd_valid;
    assign div_tick = (div_q == DIV_MAX);
    assign tck_rise = (state_q != ST_IDLE) & div_tick & ~tck_q;
    assign tck_fall = (state_q != ST_IDLE) & div_tick &  tck_q;

    // Next-state logic: sequencing, TCK divider, TDO capture and pin values.
    always_comb begin
        // NOTE: every variable gets its default first so no path infers a latch.
        state_d     = state_q;
        cnt_d       = cnt_q;
        div_d       = div_q;
        tck_d       = tck_q;
        word_d      = word_q;
        cap_d       = cap_q;
        rsp_valid_d = 1'b0;
        rsp_data_d  = rsp_data_q;
        rsp_addr_d  = rsp_addr_q;
        known_d     = known_q;
        // A reset request is remembered until the next accept, even mid-scan.
        tlr_pend_d  = tap_reset_i | (tlr_pend_q & ~accept);

        if (state_q == ST_IDLE) begin
            div_d = '0;
            tck_d = 1'b0;
            if (accept) begin
                word_d  = {host.cmd_data, host.cmd_addr};
                state_d = tlr_pend_q ? ST_TLR : ST_SEL_DR;
                cnt_d   = 4'd0;
            end
        end else begin
            div_d = div_tick ? '0 : div_q + 1'b1;
            if (div_tick) begin
                tck_d = ~tck_q;
            end
            if (tck_rise && state_q == ST_SHIFT) begin
                cap_d[cnt_q] = tdo_i;
            end
            if (tck_fall) begin
                case (state_q)
                    ST_TLR: begin
                        if (cnt_q == 4'd4) begin
                            state_d = ST_TLR_RTI;
                            cnt_d   = 4'd0;
                        end else begin
                            cnt_d = cnt_q + 4'd1;
                        end
                    end
                    ST_TLR_RTI: state_d = ST_SEL_DR;
                    ST_SEL_DR:  state_d = ST_CAP_DR;
                    ST_CAP_DR:  state_d = ST_ENT_SH;
                    ST_ENT_SH: begin
                        state_d = ST_SHIFT;
                        cnt_d   = 4'd0;
                    end
                    ST_SHIFT: begin
                        if (cnt_q == 4'd10) begin
                            state_d = ST_UPD_DR;
                        end else begin
                            cnt_d = cnt_q + 4'd1;
                        end
                    end
                    ST_UPD_DR: state_d = ST_RTI_END;
                    ST_RTI_END: begin
                        state_d     = ST_IDLE;
                        rsp_valid_d = 1'b1;
                        rsp_data_d  = cap_q[10:3];
                        rsp_addr_d  = cap_q[2:0];
                        known_d     = 1'b1;
                    end
                    default: state_d = ST_IDLE;
                endcase
            end
        end

        // Pin values for the coming rising edge; they only differ from the
        // current ones when the state advances, i.e. at a falling edge or accept.
        tdi_d = 1'b0;
        case (state_d)
            ST_IDLE:              tms_d = ~known_d;
            ST_TLR:               tms_d = 1'b1;
            ST_SEL_DR, ST_UPD_DR: tms_d = 1'b1;
            ST_SHIFT: begin
                tms_d = (cnt_d == 4'd10);
                tdi_d = word_d[cnt_d];
            end
            default:              tms_d = 1'b0;
        endcase

        ready_d = (state_d == ST_IDLE);
    end

    // State and output registers; reset aborts any scan and parks TMS high.
    always_ff @(posedge clk_sys_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q     <= ST_IDLE;
            cnt_q       <= 4'd0;
            div_q       <= '0;
            tck_q       <= 1'b0;
            tms_q       <= 1'b1;
            tdi_q       <= 1'b0;
            word_q      <= 11'd0;
            cap_q       <= 11'd0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= 8'd0;
            rsp_addr_q  <= 3'd0;
            ready_q     <= 1'b0;
            known_q     <= 1'b0;
            tlr_pend_q  <= 1'b1;
        end else begin
            // NOTE: non-blocking assignments so every register sees pre-edge values.
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            div_q       <= div_d;
            tck_q       <= tck_d;
            tms_q       <= tms_d;
            tdi_q       <= tdi_d;
            word_q      <= word_d;
            cap_q       <= cap_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            rsp_addr_q  <= rsp_addr_d;
            ready_q     <= ready_d;
            known_q     <= known_d;
            tlr_pend_q  <= tlr_pend_d;
        end
    end

    assign host.cmd_ready = ready_q;
    assign host.rsp_valid = rsp_valid_q;
    assign host.rsp_data  = rsp_data_q;
    assign host.rsp_addr  = rsp_addr_q;
    assign busy_o         = (state_q != ST_IDLE);
    assign tck_o          = tck_q;
    assign tms_o          = tms_q;
    assign tdi_o          = tdi_q;

endmodule
